// File: rtl/rca_pkg.sv
// Shared constants and types for the registered ripple-carry adder.
package rca_pkg;
    localparam int RCA_WIDTH = 4;
    typedef logic [RCA_WIDTH-1:0] rca_word_t;
endpackage

// File: rtl/full_adder_1b.sv
// 1-bit full adder cell, one stage of the ripple chain.
// Latency: combinational. Backpressure: none, pure logic.
// Carry out uses the propagate/generate form so the chain stays a single AND-OR per stage.
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic p;

    assign p    = a ^ b;
    assign sum  = p ^ cin;
    assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/rca_4_adder.sv
// Registered 4-bit ripple-carry add-with-carry: {carry, sum} = a + b + cin.
// Latency: 1 cycle, one add per cycle. Backpressure: none, inputs sampled every edge.
// Optional signed-overflow output enabled by defining RCA_4_OVF_EN.
module rca_4_adder
    import rca_pkg::*;
#(
    parameter int WIDTH = RCA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef RCA_4_OVF_EN
    ,
    output logic             ovf
`endif
);
    logic [WIDTH:0] c;
    rca_word_t      s;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder_1b u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (s[i]),
            .cout (c[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum   <= '0;
            carry <= 1'b0;
        end else begin
            sum   <= s;
            carry <= c[WIDTH];
        end
    end

`ifdef RCA_4_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else begin
            ovf <= c[WIDTH-1] ^ c[WIDTH];
        end
    end
`endif
endmodule

// File: tb/tb_rca_4_adder.sv
// Scoreboard bench for rca_4_adder: directed vectors with hand-computed results.
module tb_rca_4_adder;
    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       carry;
`ifdef RCA_4_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int passed = 0;

    // {ovf, carry, sum[3:0]}
    logic [5:0] sb[$];

    typedef struct packed {
        logic       rst;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];

    rca_4_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .carry (carry)
`ifdef RCA_4_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [5:0] exp);
        logic [5:0] act;
        logic       ok;
`ifdef RCA_4_OVF_EN
        act = {ovf, carry, sum};
        ok  = (act === exp);
`else
        act = {1'b0, carry, sum};
        ok  = (act[4:0] === exp[4:0]);
`endif
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got ovf/carry/sum=%b, want %b", name, act, exp);
    endtask

    // Monitor: a result is due one edge after each issued vector; re-check it
    // after the driver scrambles the inputs mid-cycle.
    initial begin
        logic [5:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                check("result", exp);
                #2;
                check("hold", exp);
            end
        end
    end

    initial begin
        //                 rst  a        b        cin   {ovf,carry,sum}
        vecs.push_back('{1'b1, 4'b1111, 4'b1111, 1'b1, 6'b0_0_0000}); // reset asserted (rst field = in reset)
        vecs.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 6'b0_1_1111});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 6'b0_0_0000});
        vecs.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 6'b0_1_1111});
        vecs.push_back('{1'b0, 4'b0110, 4'b0110, 1'b1, 6'b1_0_1101});
        vecs.push_back('{1'b0, 4'b0101, 4'b0101, 1'b1, 6'b1_0_1011});
        vecs.push_back('{1'b0, 4'b0100, 4'b0100, 1'b1, 6'b1_0_1001});
        vecs.push_back('{1'b0, 4'b1111, 4'b0001, 1'b1, 6'b0_1_0001});
        vecs.push_back('{1'b0, 4'b0011, 4'b0011, 1'b0, 6'b0_0_0110});
        vecs.push_back('{1'b0, 4'b0111, 4'b0001, 1'b0, 6'b1_0_1000});
        vecs.push_back('{1'b0, 4'b1000, 4'b1000, 1'b0, 6'b1_1_0000});
        vecs.push_back('{1'b0, 4'b0010, 4'b0011, 1'b0, 6'b0_0_0101});
        vecs.push_back('{1'b1, 4'b0111, 4'b0111, 1'b1, 6'b0_0_0000});
        vecs.push_back('{1'b0, 4'b1010, 4'b0101, 1'b0, 6'b0_0_1111});
        vecs.push_back('{1'b0, 4'b1001, 4'b0110, 1'b1, 6'b0_1_0000});

        rst_n = 1'b0;
        a     = 4'b0;
        b     = 4'b0;
        cin   = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = ~vecs[i].rst;
            a     = vecs[i].a;
            b     = vecs[i].b;
            cin   = vecs[i].cin;
            sb.push_back(vecs[i].exp);
            @(posedge clk);
            #2;
            a   = 4'($urandom);
            b   = 4'($urandom);
            cin = 1'($urandom);
        end

        for (int n = 0; n < 10 && sb.size() > 0; n++) @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d results outstanding, want 0", sb.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
